// File: rtl/pass_if.sv
// Data-path bundle for the pass shift register: input sample, delayed output, primed flag,
// plus per-bit edge flags when built with PASS_EDGE_DET_EN.
interface pass_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             primed;
`ifdef PASS_EDGE_DET_EN
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
`endif

    modport master (
        output in,
`ifdef PASS_EDGE_DET_EN
        input  rise,
        input  fall,
`endif
        input  out,
        input  primed
    );

    modport slave (
        input  in,
`ifdef PASS_EDGE_DET_EN
        output rise,
        output fall,
`endif
        output out,
        output primed
    );
endinterface

// File: rtl/pass.sv
// DEPTH-stage registered delay line with a saturating "primed" counter.
// Define PASS_EDGE_DET_EN to add registered per-bit rise/fall flags on out.
module pass #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic   clock,
    input  logic   reset_n,
    pass_if.slave  bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             primed;

    assign primed = (cnt_q == CW'(DEPTH));

    always_comb begin
        stage_d[0] = bus.in;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
        end
        cnt_d = primed ? cnt_q : cnt_q + CW'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
            cnt_q <= cnt_d;
        end
    end

    assign bus.out    = stage_q[DEPTH-1];
    assign bus.primed = primed;

`ifdef PASS_EDGE_DET_EN
    logic [WIDTH-1:0] out_d_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;

    // Flags compare out against its one-cycle-old copy, so they trail out by a cycle.
    always_comb begin
        rise_d = '0;
        fall_d = '0;
        if (primed) begin
            rise_d = stage_q[DEPTH-1] & ~out_d_q;
            fall_d = ~stage_q[DEPTH-1] & out_d_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_d_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            out_d_q <= stage_q[DEPTH-1];
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
`endif
endmodule

// File: tb/tb_pass.sv
// Scoreboard bench for pass: a default instance (WIDTH=1, DEPTH=1) and a WIDTH=8, DEPTH=4
// instance share clock/reset; directed rows push expected post-edge values, a monitor checks them.
module tb_pass;
    logic clk;
    logic rst_n;

    pass_if                 if1 ();
    pass_if #(.WIDTH(8))    if8 ();

    pass dut1 (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (if1)
    );

    pass #(.WIDTH(8), .DEPTH(4)) dut4 (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (if8)
    );

    typedef struct {
        int         row;
        logic       o1;
        logic       p1;
        logic       r1;
        logic       f1;
        logic [7:0] o8;
        logic       p8;
        logic [7:0] r8;
        logic [7:0] f8;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   row_n = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int row, input logic [63:0] act,
                         input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, req);
        end
    endtask

    // Inputs change mid-cycle (negedge); expectation refers to outputs after the next posedge.
    task automatic step(input logic rst, input logic i1, input logic [7:0] i8,
                        input logic o1, input logic p1, input logic r1, input logic f1,
                        input logic [7:0] o8, input logic p8,
                        input logic [7:0] r8, input logic [7:0] f8);
        exp_t e;
        @(negedge clk);
        rst_n  = rst;
        if1.in = i1;
        if8.in = i8;
        e.row = row_n;
        e.o1 = o1; e.p1 = p1; e.r1 = r1; e.f1 = f1;
        e.o8 = o8; e.p8 = p8; e.r8 = r8; e.f8 = f8;
        exp_q.push_back(e);
        row_n++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out1",    e.row, 64'(if1.out),    64'(e.o1));
                check("primed1", e.row, 64'(if1.primed), 64'(e.p1));
                check("out8",    e.row, 64'(if8.out),    64'(e.o8));
                check("primed8", e.row, 64'(if8.primed), 64'(e.p8));
`ifdef PASS_EDGE_DET_EN
                check("rise1",   e.row, 64'(if1.rise),   64'(e.r1));
                check("fall1",   e.row, 64'(if1.fall),   64'(e.f1));
                check("rise8",   e.row, 64'(if8.rise),   64'(e.r8));
                check("fall8",   e.row, 64'(if8.fall),   64'(e.f8));
`endif
            end
        end
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_n  = 1'b0;
        if1.in = 1'b0;
        if8.in = 8'h00;
        //   rst in1 in8    o1 p1 r1 f1  o8     p8 r8     f8
        step(0, 0, 8'h00,  0, 0, 0, 0,  8'h00, 0, 8'h00, 8'h00); // 0 reset
        step(0, 0, 8'h00,  0, 0, 0, 0,  8'h00, 0, 8'h00, 8'h00); // 1 reset
        step(1, 0, 8'h00,  0, 1, 0, 0,  8'h00, 0, 8'h00, 8'h00); // 2 first edge after release
        step(1, 0, 8'h00,  0, 1, 0, 0,  8'h00, 0, 8'h00, 8'h00);
        step(1, 0, 8'h00,  0, 1, 0, 0,  8'h00, 0, 8'h00, 8'h00);
        step(1, 1, 8'hA5,  1, 1, 0, 0,  8'h00, 1, 8'h00, 8'h00); // 5 A5 sampled, dut4 primed
        step(1, 0, 8'h00,  0, 1, 1, 0,  8'h00, 1, 8'h00, 8'h00);
        step(1, 0, 8'h00,  0, 1, 0, 1,  8'h00, 1, 8'h00, 8'h00);
        step(1, 1, 8'h00,  1, 1, 0, 0,  8'hA5, 1, 8'h00, 8'h00); // 8 A5 out
        step(1, 1, 8'h00,  1, 1, 1, 0,  8'h00, 1, 8'hA5, 8'h00);
        step(1, 0, 8'h00,  0, 1, 0, 0,  8'h00, 1, 8'h00, 8'hA5);
        step(1, 0, 8'h3C,  0, 1, 0, 1,  8'h00, 1, 8'h00, 8'h00);
        step(1, 1, 8'h0F,  1, 1, 0, 0,  8'h00, 1, 8'h00, 8'h00);
        step(1, 1, 8'hF0,  1, 1, 1, 0,  8'h00, 1, 8'h00, 8'h00);
        step(0, 0, 8'h00,  0, 0, 0, 0,  8'h00, 0, 8'h00, 8'h00); // 14 mid-stream reset
        step(1, 0, 8'h00,  0, 1, 0, 0,  8'h00, 0, 8'h00, 8'h00);
        step(1, 0, 8'h00,  0, 1, 0, 0,  8'h00, 0, 8'h00, 8'h00);
        step(1, 0, 8'h00,  0, 1, 0, 0,  8'h00, 0, 8'h00, 8'h00);
        step(1, 0, 8'h00,  0, 1, 0, 0,  8'h00, 1, 8'h00, 8'h00);
        step(1, 0, 8'h00,  0, 1, 0, 0,  8'h00, 1, 8'h00, 8'h00);
        step(1, 1, 8'hFF,  1, 1, 0, 0,  8'h00, 1, 8'h00, 8'h00); // 20 constant FF held
        step(1, 1, 8'hFF,  1, 1, 1, 0,  8'h00, 1, 8'h00, 8'h00);
        step(1, 1, 8'hFF,  1, 1, 0, 0,  8'h00, 1, 8'h00, 8'h00);
        step(1, 1, 8'hFF,  1, 1, 0, 0,  8'hFF, 1, 8'h00, 8'h00);
        step(1, 0, 8'h00,  0, 1, 0, 0,  8'hFF, 1, 8'hFF, 8'h00);
        step(1, 0, 8'h00,  0, 1, 0, 1,  8'hFF, 1, 8'h00, 8'h00);
        step(1, 0, 8'h00,  0, 1, 0, 0,  8'hFF, 1, 8'h00, 8'h00);
        step(1, 0, 8'h00,  0, 1, 0, 0,  8'h00, 1, 8'h00, 8'h00);
        step(1, 0, 8'h00,  0, 1, 0, 0,  8'h00, 1, 8'h00, 8'hFF);
        step(1, 0, 8'h00,  0, 1, 0, 0,  8'h00, 1, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pass.md
PASS -- requirements
Module: pass

Interface
REQ-001 Parameter WIDTH, default 1: bit width of the data path, legal range 1..64.
REQ-002 Parameter DEPTH, default 1: number of register stages (latency in cycles), legal range 1..16.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 in  input  WIDTH  data sampled every rising clock edge.
REQ-006 out  output  WIDTH  data from the last register stage.
REQ-007 primed  output  1  high once DEPTH valid samples have entered since reset release.
REQ-008 rise  output  WIDTH  per-bit rising-edge flag on out; present only with PASS_EDGE_DET_EN.
REQ-009 fall  output  WIDTH  per-bit falling-edge flag on out; present only with PASS_EDGE_DET_EN.

Function
REQ-010 The block SHALL be a DEPTH-stage shift register: stage0 <= in; stage k <= stage k-1; out = stage DEPTH-1.
REQ-011 out SHALL equal the value of in sampled DEPTH rising edges earlier; with default DEPTH=1, out follows in one cycle later.
REQ-012 out SHALL be driven directly from a register, with no combinational path from in to out.
REQ-013 A change on in between edges SHALL NOT affect out until the next sampling edge plus DEPTH-1 cycles.
REQ-014 primed SHALL be driven by a saturating counter, width ceil(log2(DEPTH+1)): it increments each non-reset cycle and saturates at DEPTH.
REQ-015 primed SHALL be high whenever that counter equals DEPTH.
REQ-016 All WIDTH bits SHALL be handled independently and identically, with no arithmetic or reordering.
REQ-017 A constant input held for at least DEPTH cycles SHALL produce the same constant on out.

Reset
REQ-018 While reset_n is sampled low at a rising edge, all stages SHALL clear to 0, the primed counter SHALL clear to 0, and rise and fall SHALL clear to 0.
REQ-019 Reset asserted mid-operation SHALL discard all in-flight data; out SHALL be 0 from the edge after reset is sampled.
REQ-020 After reset_n goes high, the first sample SHALL be taken on the next rising edge.
REQ-021 primed SHALL go high after DEPTH non-reset edges.
REQ-022 No output SHALL change asynchronously with reset_n.

Configuration
REQ-023 Macro PASS_EDGE_DET_EN SHALL control the edge-detection feature.
REQ-024 When PASS_EDGE_DET_EN is defined, the block SHALL hold a registered copy of out (out_d).
REQ-025 When PASS_EDGE_DET_EN is defined: rise = out & ~out_d and fall = ~out & out_d, both registered, each valid for one cycle.
REQ-026 Edge flags SHALL be suppressed while primed is low.
REQ-027 When PASS_EDGE_DET_EN is undefined, the rise and fall ports and their logic SHALL be absent, and the out and primed behaviour SHALL be unchanged.

Verification
REQ-028 Default params; reset low for 2 edges, then in=0 for 3 edges -> out=0, primed=1 after the first edge following reset release.
REQ-029 in=1 applied 5 ns after an edge -> out=0 at once; out=1 5 ns after the next edge; in=0 then -> out=0 one edge later.
REQ-030 DEPTH=4, WIDTH=8; in=0xA5 for one cycle, then 0x00 -> out=0xA5 for exactly one cycle, 4 edges after sampling.
REQ-031 Reset mid-stream with DEPTH=4 and non-zero data in flight -> out=0 and primed=0 on the next edge; old data never reappears.
REQ-032 PASS_EDGE_DET_EN defined; in toggles 0->1->0 -> rise pulses for 1 cycle after out rises, and fall pulses for 1 cycle after out falls.
REQ-033 Same bench with PASS_EDGE_DET_EN undefined -> out and primed waveforms identical to REQ-028 to REQ-031.
